stb_channel_scheduler: RTL and testbench

- Single-clock scheduler that shares one cross-domain strobe channel (a sticky-flop/ack strobe synchronizer) among NREQ event sources in the source clock domain.
- Captures single-cycle request pulses into sticky pending bits and grants them round-robin.
- Issues one strobe pulse per grant with a stable requester ID for the far side to sample.
- Enforces a minimum hold-off between strobes, so the synchronizer never sees a new rising strobe while its previous round trip is in flight.

---
 rtl/stb_channel_scheduler.sv | 132 +++++++++++++
 tb/tb_stb_channel_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/stb_channel_scheduler.sv
// Round-robin scheduler sharing one strobe synchronizer channel among NREQ
// pulse sources, with sticky pending/overrun flags and a strobe hold-off.
module stb_channel_scheduler #(
  parameter int NREQ    = 4,
  parameter int HOLDOFF = 8,
  parameter int IW      = 2
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_enable,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_clr_overrun,
  output logic            o_stb,
  output logic [IW-1:0]   o_id,
  output logic [NREQ-1:0] o_pending,
  output logic [NREQ-1:0] o_overrun,
  output logic            o_busy
);

  localparam int              CW        = (HOLDOFF > 2) ? $clog2(HOLDOFF) : 1;
  localparam logic [CW-1:0]   HOLD_LOAD = CW'(HOLDOFF - 1);
  localparam logic [IW:0]     NREQ_W    = (IW + 1)'(NREQ);
  localparam logic [IW-1:0]   LAST_ID   = IW'(NREQ - 1);

  typedef enum logic {
    ST_READY = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   id_q, id_d;
  logic            stb_q, stb_d;
  logic [NREQ-1:0] pending_q, pending_d;
  logic [NREQ-1:0] overrun_q, overrun_d;

  logic [IW:0]     cand_s;
  logic [IW-1:0]   winner_s;
  logic            grant_s;
  logic [NREQ-1:0] grant_vec_s;
  logic [NREQ-1:0] new_ovr_s;

  // Round-robin winner: scan downward so the last hit is the closest at/after the pointer.
  always_comb begin
    cand_s   = {(IW + 1){1'b0}};
    winner_s = ptr_q;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand_s = {1'b0, ptr_q} + (IW + 1)'(i);
      if (cand_s >= NREQ_W) begin
        cand_s = cand_s - NREQ_W;
      end else begin
        cand_s = cand_s;
      end
      if (pending_q[cand_s[IW-1:0]]) begin
        winner_s = cand_s[IW-1:0];
      end else begin
        winner_s = winner_s;
      end
    end
  end

  // Next-state: hold-off FSM, grant issue, pending/overrun bookkeeping.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    stb_d     = 1'b0;

    grant_s     = (state_q == ST_READY) && i_enable && (pending_q != {NREQ{1'b0}});
    grant_vec_s = grant_s ? (NREQ'(1) << winner_s) : {NREQ{1'b0}};
    // A request landing on its own grant edge re-arms pending without counting as lost.
    new_ovr_s   = i_req & pending_q & ~grant_vec_s;
    pending_d   = (pending_q & ~grant_vec_s) | i_req;
    overrun_d   = (i_clr_overrun ? {NREQ{1'b0}} : overrun_q) | new_ovr_s;

    case (state_q)
      ST_READY: begin
        if (grant_s) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LOAD;
          stb_d   = 1'b1;
          id_d    = winner_s;
          ptr_d   = (winner_s == LAST_ID) ? {IW{1'b0}} : winner_s + IW'(1);
        end else begin
          cnt_d = {CW{1'b0}};
        end
      end
      ST_HOLD: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_READY;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // State register with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_READY;
      cnt_q     <= {CW{1'b0}};
      ptr_q     <= {IW{1'b0}};
      id_q      <= {IW{1'b0}};
      stb_q     <= 1'b0;
      pending_q <= {NREQ{1'b0}};
      overrun_q <= {NREQ{1'b0}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      stb_q     <= stb_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_stb     = stb_q;
  assign o_id      = id_q;
  assign o_pending = pending_q;
  assign o_overrun = overrun_q;
  assign o_busy    = stb_q | (cnt_q != {CW{1'b0}});

endmodule

// File: tb/tb_stb_channel_scheduler.sv
// Self-checking bench: directed vector table, corner sequences and random
// stimulus compared against a behavioural scheduler model.
module tb_stb_channel_scheduler;
  localparam int NREQ    = 4;
  localparam int HOLDOFF = 8;
  localparam int IW      = 2;

  logic            i_clk = 1'b0;
  logic            i_reset;
  logic            i_enable;
  logic [NREQ-1:0] i_req;
  logic            i_clr_overrun;
  logic            o_stb;
  logic [IW-1:0]   o_id;
  logic [NREQ-1:0] o_pending;
  logic [NREQ-1:0] o_overrun;
  logic            o_busy;

  stb_channel_scheduler #(.NREQ(NREQ), .HOLDOFF(HOLDOFF), .IW(IW)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_req(i_req),
    .i_clr_overrun(i_clr_overrun), .o_stb(o_stb), .o_id(o_id),
    .o_pending(o_pending), .o_overrun(o_overrun), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  // Behavioural model state
  bit m_pend[NREQ];
  bit m_ovr[NREQ];
  int m_cnt, m_ptr, m_id;
  bit m_stb;

  typedef struct {
    logic [3:0] req; logic en; logic clr;
    logic stb; logic [1:0] id; logic [3:0] pend; logic [3:0] ovr; logic busy;
  } vec_t;
  vec_t tbl[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NREQ-1:0] pack(input bit v[NREQ]);
    logic [NREQ-1:0] r;
    for (int k = 0; k < NREQ; k++) r[k] = v[k];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NREQ; k++) begin m_pend[k] = 0; m_ovr[k] = 0; end
    m_cnt = 0; m_ptr = 0; m_id = 0; m_stb = 0;
  endtask

  task automatic model_step(input logic [NREQ-1:0] req, input logic en, input logic clr);
    bit any;
    bit grant;
    int w;
    any = 0;
    w = -1;
    for (int i = 0; i < NREQ; i++) begin
      if (w < 0 && m_pend[(m_ptr + i) % NREQ]) w = (m_ptr + i) % NREQ;
      if (m_pend[i]) any = 1;
    end
    grant = (m_cnt == 0) && en && any;
    for (int k = 0; k < NREQ; k++) begin
      bit mine;
      mine = grant && (k == w);
      if (req[k] && m_pend[k] && !mine) m_ovr[k] = 1;
      else if (clr) m_ovr[k] = 0;
      m_pend[k] = mine ? req[k] : (m_pend[k] | req[k]);
    end
    if (grant) begin
      m_stb = 1; m_id = w; m_ptr = (w + 1) % NREQ; m_cnt = HOLDOFF - 1;
    end else begin
      m_stb = 0;
      if (m_cnt > 0) m_cnt--;
    end
  endtask

  task automatic compare_model();
    check("stb", o_stb, m_stb);
    check("id", o_id, m_id);
    check("pending", o_pending, pack(m_pend));
    check("overrun", o_overrun, pack(m_ovr));
    check("busy", o_busy, (m_stb || m_cnt != 0));
  endtask

  task automatic tick(input logic [NREQ-1:0] req, input logic en, input logic clr);
    i_req = req; i_enable = en; i_clr_overrun = clr;
    model_step(req, en, clr);
    @(posedge i_clk);
    #1;
    cyc++;
    compare_model();
  endtask

  task automatic reset_dut();
    i_reset = 1'b1; i_req = '0; i_enable = 1'b0; i_clr_overrun = 1'b0;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int stb_t[$];
    int stb_i[$];
    int first_id;
    i_reset = 1'b1; i_req = '0; i_enable = 1'b0; i_clr_overrun = 1'b0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    check("reset_stb", o_stb, 1'b0);
    check("reset_id", o_id, 2'd0);
    check("reset_pending", o_pending, 4'b0000);
    check("reset_overrun", o_overrun, 4'b0000);
    check("reset_busy", o_busy, 1'b0);

    // Directed table: single event, overrun/clear interplay, coincident grant, spacing
    tbl[0] = '{4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0100, 4'b0000, 1'b0};
    tbl[1] = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0000, 4'b0000, 1'b1};
    tbl[2] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 4'b0000, 1'b1};
    tbl[3] = '{4'b0010, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0010, 4'b0000, 1'b1};
    tbl[4] = '{4'b0010, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0010, 4'b0010, 1'b1};
    tbl[5] = '{4'b0010, 1'b1, 1'b1, 1'b0, 2'd2, 4'b0010, 4'b0010, 1'b1};
    tbl[6] = '{4'b0000, 1'b1, 1'b1, 1'b0, 2'd2, 4'b0010, 4'b0000, 1'b1};
    tbl[7] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0010, 4'b0000, 1'b1};
    tbl[8] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0010, 4'b0000, 1'b0};
    tbl[9] = '{4'b0010, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0010, 4'b0000, 1'b1};
    for (int r = 10; r < 16; r++)
      tbl[r] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0010, 4'b0000, 1'b1};
    tbl[16] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0010, 4'b0000, 1'b0};
    tbl[17] = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0000, 4'b0000, 1'b1};
    for (int r = 0; r < 18; r++) begin
      tick(tbl[r].req, tbl[r].en, tbl[r].clr);
      check($sformatf("tbl%0d_stb", r), o_stb, tbl[r].stb);
      check($sformatf("tbl%0d_id", r), o_id, tbl[r].id);
      check($sformatf("tbl%0d_pend", r), o_pending, tbl[r].pend);
      check($sformatf("tbl%0d_ovr", r), o_overrun, tbl[r].ovr);
      check($sformatf("tbl%0d_busy", r), o_busy, tbl[r].busy);
    end

    // Enable gating, then round robin order and spacing
    reset_dut();
    tick(4'b1111, 1'b0, 1'b0);
    for (int n = 0; n < 3; n++) begin
      tick(4'b0000, 1'b0, 1'b0);
      check("gated_no_stb", o_stb, 1'b0);
    end
    check("gated_pending", o_pending, 4'b1111);
    tick(4'b0000, 1'b1, 1'b0);
    check("enable_stb", o_stb, 1'b1);
    check("enable_id", o_id, 2'd0);
    stb_t.push_back(cyc); stb_i.push_back(0);
    for (int n = 0; n < 30; n++) begin
      tick(4'b0000, 1'b1, 1'b0);
      if (o_stb) begin stb_t.push_back(cyc); stb_i.push_back(o_id); end
    end
    check("rr_grant_count", stb_t.size(), 4);
    for (int i = 1; i < stb_t.size() && i < 4; i++) begin
      check($sformatf("rr_id%0d", i), stb_i[i], i);
      check($sformatf("rr_gap%0d", i), stb_t[i] - stb_t[i-1], HOLDOFF);
    end
    tick(4'b1111, 1'b1, 1'b0);
    first_id = -1;
    for (int n = 0; n < 12 && first_id < 0; n++) begin
      tick(4'b0000, 1'b1, 1'b0);
      if (o_stb) first_id = o_id;
    end
    check("rr_wrap_to_0", first_id, 0);

    // Fairness after wrap: pointer at 3 with sources 3 and 0 pending
    reset_dut();
    tick(4'b0100, 1'b1, 1'b0);
    tick(4'b0000, 1'b1, 1'b0);
    tick(4'b1001, 1'b1, 1'b0);
    stb_i.delete();
    for (int n = 0; n < 24; n++) begin
      tick(4'b0000, 1'b1, 1'b0);
      if (o_stb) stb_i.push_back(o_id);
    end
    check("wrap_count", stb_i.size(), 2);
    if (stb_i.size() >= 2) begin
      check("wrap_first", stb_i[0], 3);
      check("wrap_second", stb_i[1], 0);
    end

    // Async reset between edges during hold-off
    reset_dut();
    tick(4'b1000, 1'b1, 1'b0);
    tick(4'b0110, 1'b1, 1'b0);
    check("pre_reset_grant", o_stb, 1'b1);
    repeat (3) tick(4'b0000, 1'b1, 1'b0);
    #3;
    i_reset = 1'b1;
    #1;
    check("async_stb", o_stb, 1'b0);
    check("async_id", o_id, 2'd0);
    check("async_pending", o_pending, 4'b0000);
    check("async_overrun", o_overrun, 4'b0000);
    check("async_busy", o_busy, 1'b0);
    model_reset();
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    tick(4'b0010, 1'b1, 1'b0);
    tick(4'b0000, 1'b1, 1'b0);
    check("post_reset_stb", o_stb, 1'b1);
    check("post_reset_id", o_id, 2'd1);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [NREQ-1:0] rq;
      for (int k = 0; k < NREQ; k++) rq[k] = ($urandom_range(0, 7) == 0);
      tick(rq, ($urandom_range(0, 9) != 0), ($urandom_range(0, 15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
